// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register (with complementary
// output) among NREQ requesters via a req/gnt/ack handshake.
module dff_bank_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       ack_o,
    output logic [WIDTH-1:0]      q_o,
    output logic [WIDTH-1:0]      qb_o,
    output logic                  busy_o,
    output logic [IDW-1:0]        owner_o
);

    typedef enum logic [1:0] {StIdle, StGrant, StAck} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     win_q, win_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   qb_q, qb_d;
    logic [IDW-1:0]     pick_idx;
    logic [WIDTH-1:0]   wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign wdata_arr[i] = wdata_i[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: first set request scanning from ptr upward, modulo NREQ.
    // Descending loop so the closest-to-ptr candidate is assigned last and wins.
    always_comb begin
        pick_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_q) + k) % NREQ]) begin
                pick_idx = IDW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end

    // State and datapath registers; synchronous reset aborts any in-flight grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            win_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            qb_q    <= '1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            qb_q    <= qb_d;
        end
    end

    // Next-state and commit logic; gnt/ack default to zero so they pulse.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = '0;
        ack_d   = '0;
        q_d     = q_q;
        qb_d    = qb_q;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    win_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (req_i[win_q]) begin
                    q_d     = wdata_arr[win_q];
                    qb_d    = ~wdata_arr[win_q];
                    owner_d = win_q;
                    ptr_d   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    ack_d   = NREQ'(1) << win_q;
                    state_d = StAck;
                end else begin
                    // Requester withdrew: abort without touching ptr or owner.
                    state_d = StIdle;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come straight from registers; busy decodes the state register.
    always_comb begin
        gnt_o   = gnt_q;
        ack_o   = ack_q;
        q_o     = q_q;
        qb_o    = qb_q;
        owner_o = owner_q;
        busy_o  = (state_q != StIdle);
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: directed scenarios plus random
// traffic, compared cycle by cycle against a transaction-level model.
module tb_dff_bank_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [W-1:0]   qb;
    logic           busy;
    logic [1:0]     owner;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: phase 0=waiting, 1=granted, 2=acknowledging
    int         m_phase;
    int         m_w;
    int         m_ptr;
    int         m_owner;
    logic [W-1:0] m_q;

    int           rr_owner [$];
    int           rr_cyc   [$];
    logic [W-1:0] rr_q     [$];
    logic [N-1:0] drop_mask;

    dff_bank_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .wdata_i (wdata),
        .gnt_o   (gnt),
        .ack_o   (ack),
        .q_o     (q),
        .qb_o    (qb),
        .busy_o  (busy),
        .owner_o (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rs, input logic [N-1:0] r, input logic [N*W-1:0] d);
        if (rs) begin
            m_phase = 0; m_q = '0; m_owner = 0; m_ptr = 0; m_w = 0;
        end else if (m_phase == 0) begin
            if (r != '0) begin
                m_w = first_from(m_ptr, r);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (r[m_w]) begin
                m_q     = d[m_w*W +: W];
                m_owner = m_w;
                m_ptr   = (m_w + 1) % N;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_all();
        logic [W-1:0] e_qb;
        e_qb = ~m_q;
        chk("gnt",   32'(gnt),   (m_phase == 1) ? (32'd1 << m_w) : 32'd0);
        chk("ack",   32'(ack),   (m_phase == 2) ? (32'd1 << m_w) : 32'd0);
        chk("q",     32'(q),     32'(m_q));
        chk("qb",    32'(qb),    32'(e_qb));
        chk("busy",  32'(busy),  (m_phase != 0) ? 32'd1 : 32'd0);
        chk("owner", 32'(owner), 32'(m_owner));
    endtask

    task automatic tick();
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        logic           rs;
        r = req; d = wdata; rs = rst;
        @(posedge clk);
        #1;
        model_step(rs, r, d);
        check_all();
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q"},     32'(q),     32'h00);
        chk({tag, "_qb"},    32'(qb),    32'hFF);
        chk({tag, "_gnt"},   32'(gnt),   32'h0);
        chk({tag, "_ack"},   32'(ack),   32'h0);
        chk({tag, "_busy"},  32'(busy),  32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; wdata = $urandom;

        // Reset with all requests asserted
        tick(); chk_reset_vals("rst1");
        tick(); chk_reset_vals("rst2");
        rst = 1'b0; req = '0;
        tick(); chk_reset_vals("rst_rel");

        // Single write from requester 2
        req = 4'b0100; wdata = 32'h00A5_0000;
        tick(); chk("single_gnt", 32'(gnt), 32'b0100);
        tick();
        chk("single_q",     32'(q),     32'hA5);
        chk("single_qb",    32'(qb),    32'h5A);
        chk("single_ack",   32'(ack),   32'b0100);
        chk("single_owner", 32'(owner), 32'd2);
        req = '0;
        tick(); chk("single_busy", 32'(busy), 32'd0);

        // Round-robin fairness with all four requesting
        do_reset();
        wdata = 32'h1312_1110;
        drop_mask = '0;
        for (int i = 0; i < 16; i++) begin
            req = 4'b1111 & ~drop_mask;
            tick();
            drop_mask = (m_phase == 2) ? N'(1 << m_w) : '0;
            if (ack != '0) begin
                rr_owner.push_back(int'(owner));
                rr_q.push_back(q);
                rr_cyc.push_back(cyc);
            end
        end
        chk("rr_count", 32'(rr_owner.size()), 32'd5);
        for (int i = 0; i < 5 && i < rr_owner.size(); i++) begin
            chk("rr_order", 32'(rr_owner[i]), 32'(i % 4));
            chk("rr_q",     32'(rr_q[i]),     32'h10 + 32'(i % 4));
            if (i > 0) chk("rr_spacing", 32'(rr_cyc[i] - rr_cyc[i-1]), 32'd3);
        end
        req = '0;
        tick();

        // Abort: requester 1 withdraws during grant
        do_reset();
        wdata = 32'h4433_2211;
        req = 4'b0010;
        tick(); chk("abort_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        chk("abort_ack",  32'(ack),  32'h0);
        chk("abort_q",    32'(q),    32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        req = 4'b0011;
        tick(); chk("abort_ptr_gnt", 32'(gnt), 32'b0001);
        tick(); chk("abort_commit_q", 32'(q), 32'h11);
        req = '0;
        tick();

        // Reset during grant must not commit
        do_reset();
        wdata = 32'h0000_FF00;
        req = 4'b0010;
        tick(); chk("midrst_gnt", 32'(gnt), 32'b0010);
        rst = 1'b1;
        tick(); chk_reset_vals("midrst");
        rst = 1'b0; req = '0;
        tick();
        chk("midrst_q_after",    32'(q),    32'h00);
        chk("midrst_busy_after", 32'(busy), 32'h0);

        // Wrap-around: requester 3 commits, ptr returns to 0
        wdata = 32'h3300_0077;
        req = 4'b1000;
        tick(); tick();
        chk("wrap_owner3", 32'(owner), 32'd3);
        req = '0;
        tick();
        req = 4'b1001;
        tick(); chk("wrap_gnt0", 32'(gnt), 32'b0001);
        tick(); chk("wrap_q0",   32'(q),   32'h77);
        req = 4'b1000;
        tick();
        req = 4'b1001;
        tick(); chk("wrap_gnt3", 32'(gnt), 32'b1000);
        tick(); chk("wrap_q3",   32'(q),   32'h33);
        req = '0;
        tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom_range(0, 15));
            wdata = $urandom;
            rst   = ($urandom_range(0, 39) == 0);
            tick();
        end
        rst = 1'b0; req = '0;
        tick(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter that shares one WIDTH-bit register (a bank of D flip-flops with complementary outputs) among NREQ requesters. It uses a three-state req/gnt/ack handshake and commits exactly one requester's data per transaction. It sits between the flip-flop storage primitives and the blocks that need to update shared state.

## Interface
- WIDTH, 8, bit width of the shared register
- NREQ, 4, number of requesters (2..16); IDW = $clog2(NREQ)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*WIDTH  flattened write data; requester i drives bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot one-cycle write-committed pulse, registered
- q  out  WIDTH  shared register contents
- qb  out  WIDTH  registered complement of q
- busy  out  1  high whenever state != IDLE
- owner  out  IDW  index of the last requester whose write committed

## Operation
- Reset, synchronous with rst=1 at a rising edge:
  - state=IDLE, q=0, qb=all ones, gnt=0, ack=0, busy=0, owner=0, ptr=0.
  - Reset overrides every transition, including an in-flight GRANT. No write commits in that case.
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - gnt=0, ack=0.
  - If any req bit is high, select winner w: the first set bit of req scanning ptr, ptr+1, … modulo NREQ.
  - Register w, set gnt to one-hot(w), go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - gnt[w]=1.
  - If req[w]=1 at the edge (commit):
    - q takes wdata slice w and qb takes ~wdata slice w.
    - owner=w, ptr=(w+1) mod NREQ.
    - gnt=0, ack=one-hot(w), go to ACK.
  - If req[w]=0 at the edge (abort):
    - No write, no ack. ptr and owner are unchanged.
    - gnt=0, go to IDLE.
- ACK:
  - ack[w]=1 for exactly this cycle. No arbitration takes place.
  - Next edge: ack=0, go to IDLE.
  - The requester must drop req at or before the edge that ends ACK, or it is re-arbitrated as a new request.
- Requests from non-winning requesters are held pending and ignored until the next IDLE evaluation. Only req[w] and the wdata slice w are sampled during GRANT.
- qb equals ~q in every cycle, including immediately after reset.

## Timing
- A request first seen high at edge E0 in IDLE produces:
  - gnt high during cycle E0..E1.
  - q/qb updated at E1, with ack high during cycle E1..E2.
  - Back in IDLE after E2.
- Minimum spacing between commits is 3 cycles. Sustained throughput with continuous requests is one write per 3 cycles.
- Latency from request to data visible on q is 2 edges.
- All outputs are registered. There is no combinational path from req/wdata to any output.
- Simultaneous requests resolve in round-robin order. With NREQ=4 and all four held continuously after reset, grants go 0,1,2,3,0,…
- Wrap-around: a winner of NREQ-1 sets ptr=0.
- A requester is starved for at most NREQ-1 other commits.

## Test plan
- Reset check:
  - Drive rst=1 for 2 cycles with req=4'b1111.
  - Required: q=8'h00, qb=8'hFF, gnt=0, ack=0, busy=0, owner=0, in every cycle while rst is high and in the first cycle after it is released.
- Single write:
  - After reset, req=4'b0100 with slice 2 = 8'hA5.
  - Required: gnt=4'b0100 for 1 cycle. Then q=8'hA5, qb=8'h5A, ack=4'b0100, owner=2 for 1 cycle. Then busy=0.
- Round-robin fairness:
  - Hold req=4'b1111 with slice i = 8'h10+i, and drop each bit for 1 cycle after its ack.
  - Required: commit order 0,1,2,3,0. q steps 8'h10,8'h11,8'h12,8'h13. Each commit is spaced exactly 3 cycles apart.
- Abort:
  - req=4'b0010 for 1 cycle only.
  - Required: gnt=4'b0010 for one cycle, no ack, q unchanged, ptr unchanged. A subsequent req=4'b0011 grants requester 0 when ptr=0.
- Reset mid-transaction:
  - Assert rst during GRANT for requester 1 with slice 1 = 8'hFF.
  - Required: q stays 8'h00, no ack, state returns to IDLE.
- Wrap-around:
  - Commit requester 3, then raise req=4'b1001.
  - Required: requester 0 is granted before requester 3.
